// File: rtl/var_decider_pkg.sv
// Shared definitions for the DPLL decision-variable selector: index width,
// variable-state encoding and the selector FSM state type.
package var_decider_pkg;

  localparam int MAX_VARS_BITS = 6;

  localparam logic [1:0] VAR_UNASSIGNED = 2'b00;
  localparam logic [1:0] VAR_FALSE      = 2'b01;
  localparam logic [1:0] VAR_TRUE       = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } dec_state_e;

endpackage

// File: rtl/var_decider.sv
// Decision-variable selector: scans the assignment table upward from a retained
// pointer and pushes the lowest unassigned index into the decider stack.
module var_decider
  import var_decider_pkg::*;
#(
  parameter int NUM_VARS = 64,
  parameter int IDX_W    = MAX_VARS_BITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             rewind,
  input  logic [IDX_W-1:0] rewind_idx,
  output logic             var_rd_en,
  output logic [IDX_W-1:0] var_rd_idx,
  input  logic [1:0]       var_rd_state,
  output logic             dec_push,
  output logic [IDX_W-1:0] dec_idx,
  output logic             all_assigned,
  output logic             busy
);

  localparam logic [IDX_W:0] NUM_PTR_C  = (IDX_W+1)'(NUM_VARS);
  localparam logic [IDX_W:0] LAST_PTR_C = (IDX_W+1)'(NUM_VARS - 1);
  localparam logic [IDX_W:0] ONE_PTR_C  = (IDX_W+1)'(1);

  dec_state_e       state_r, state_s;
  logic [IDX_W:0]   scan_ptr_r, scan_ptr_s;
  logic [IDX_W:0]   rd_ptr_r, rd_ptr_s;
  logic [IDX_W:0]   base_ptr_s;
  logic             chk_vld_r, chk_vld_s;
  logic [IDX_W-1:0] chk_idx_r, chk_idx_s;
  logic             rd_en_r, rd_en_s;
  logic [IDX_W-1:0] rd_idx_r, rd_idx_s;
  logic             push_r, push_s;
  logic [IDX_W-1:0] push_idx_r, push_idx_s;
  logic             all_r, all_s;
  logic             busy_r;

  function automatic logic [IDX_W:0] ptr_min(input logic [IDX_W:0] a, input logic [IDX_W:0] b);
    if (a < b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Next-state, pointer and output decode; chk_* tracks which index the current response belongs to.
  always_comb begin
    state_s    = state_r;
    scan_ptr_s = scan_ptr_r;
    rd_ptr_s   = rd_ptr_r;
    rd_en_s    = 1'b0;
    rd_idx_s   = rd_idx_r;
    push_s     = 1'b0;
    push_idx_s = push_idx_r;
    all_s      = 1'b0;
    if (rewind) begin
      base_ptr_s = ptr_min(scan_ptr_r, {1'b0, rewind_idx});
    end else begin
      base_ptr_s = scan_ptr_r;
    end
    case (state_r)
      ST_IDLE: begin
        scan_ptr_s = base_ptr_s;
        if (start) begin
          if (base_ptr_s < NUM_PTR_C) begin
            state_s  = ST_SCAN;
            rd_en_s  = 1'b1;
            rd_idx_s = base_ptr_s[IDX_W-1:0];
            rd_ptr_s = base_ptr_s + ONE_PTR_C;
          end else begin
            all_s = 1'b1;
          end
        end else begin
          all_s = 1'b0;
        end
      end
      ST_SCAN: begin
        // Abort wins over any response arriving in the same cycle.
        if (rewind) begin
          scan_ptr_s = base_ptr_s;
          state_s    = ST_IDLE;
        end else if (chk_vld_r && (var_rd_state == VAR_UNASSIGNED)) begin
          push_s     = 1'b1;
          push_idx_s = chk_idx_r;
          scan_ptr_s = {1'b0, chk_idx_r} + ONE_PTR_C;
          state_s    = ST_IDLE;
        end else if (chk_vld_r && ({1'b0, chk_idx_r} == LAST_PTR_C)) begin
          all_s      = 1'b1;
          scan_ptr_s = NUM_PTR_C;
          state_s    = ST_IDLE;
        end else if (rd_ptr_r < NUM_PTR_C) begin
          rd_en_s  = 1'b1;
          rd_idx_s = rd_ptr_r[IDX_W-1:0];
          rd_ptr_s = rd_ptr_r + ONE_PTR_C;
        end else begin
          rd_en_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    chk_vld_s = rd_en_r && (state_s == ST_SCAN);
    chk_idx_s = rd_idx_r;
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      scan_ptr_r <= '0;
      rd_ptr_r   <= '0;
      chk_vld_r  <= 1'b0;
      chk_idx_r  <= '0;
      rd_en_r    <= 1'b0;
      rd_idx_r   <= '0;
      push_r     <= 1'b0;
      push_idx_r <= '0;
      all_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      scan_ptr_r <= scan_ptr_s;
      rd_ptr_r   <= rd_ptr_s;
      chk_vld_r  <= chk_vld_s;
      chk_idx_r  <= chk_idx_s;
      rd_en_r    <= rd_en_s;
      rd_idx_r   <= rd_idx_s;
      push_r     <= push_s;
      push_idx_r <= push_idx_s;
      all_r      <= all_s;
      busy_r     <= (state_s == ST_SCAN);
    end
  end

  assign var_rd_en    = rd_en_r;
  assign var_rd_idx   = rd_idx_r;
  assign dec_push     = push_r;
  assign dec_idx      = push_idx_r;
  assign all_assigned = all_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_var_decider.sv
// Bench for var_decider with an 8-entry assignment table: directed vectors,
// randomized scans against a latency/result model, and abort/reset sequences.
module tb_var_decider;
  import var_decider_pkg::*;

  localparam int NV = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       rewind = 1'b0;
  logic [5:0] rewind_idx = 6'd0;
  logic       var_rd_en;
  logic [5:0] var_rd_idx;
  logic [1:0] var_rd_state = 2'b01;
  logic       dec_push;
  logic [5:0] dec_idx;
  logic       all_assigned;
  logic       busy;

  logic [15:0] tab_bits = 16'h0000;
  int total = 0;
  int bad = 0;
  int mdl_sp = 0;

  typedef struct {
    logic [15:0] tab;
    int          rw_mode;
    logic [5:0]  rw_idx;
    int          e_kind;
    int          e_idx;
    int          e_lat;
    int          e_nrd;
    int          e_first;
  } vec_t;

  vec_t vecs[9];

  var_decider #(.NUM_VARS(NV)) dut (
    .clock(clock), .reset(reset), .start(start), .rewind(rewind),
    .rewind_idx(rewind_idx), .var_rd_en(var_rd_en), .var_rd_idx(var_rd_idx),
    .var_rd_state(var_rd_state), .dec_push(dec_push), .dec_idx(dec_idx),
    .all_assigned(all_assigned), .busy(busy)
  );

  always #5 clock = ~clock;

  // Assignment table: one-cycle read latency, junk data when no read was issued.
  always @(posedge clock) begin
    if (var_rd_en && (var_rd_idx < 6'd8)) begin
      var_rd_state <= tab_bits[var_rd_idx*2 +: 2];
    end else begin
      var_rd_state <= 2'($urandom);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Outcome of one start from pointer sp: 1=push, 2=all_assigned; latency in cycles after start.
  function automatic void model(input int sp, input logic [15:0] t, output int k, output int i,
                                output int l, output int n, output int f, output int nsp);
    k = 2; i = -1; f = (sp < NV) ? sp : -1;
    if (sp >= NV) begin
      l = 1; n = 0; nsp = NV;
      return;
    end
    l = 2 + NV - sp; n = NV - sp; nsp = NV;
    for (int j = NV - 1; j >= sp; j--) begin
      if (t[2*j +: 2] == 2'b00) begin
        k = 1; i = j; l = 3 + j - sp;
        n = (j - sp + 2 < NV - sp) ? j - sp + 2 : NV - sp;
        nsp = j + 1;
      end
    end
  endfunction

  task automatic do_rewind(input logic [5:0] ri);
    @(negedge clock);
    rewind = 1'b1; rewind_idx = ri;
    @(posedge clock);
    #1 rewind = 1'b0;
  endtask

  task automatic run_start(input bit rw, input logic [5:0] ri, output int kind, output int idx,
                           output int lat, output int nreads, output int first,
                           output int both, output int busy_evt, output int seq_ok);
    kind = 0; idx = -1; lat = -1; nreads = 0; first = -1; both = 0; busy_evt = -1; seq_ok = 1;
    @(negedge clock);
    start = 1'b1; rewind = rw; rewind_idx = ri;
    @(posedge clock);
    #1 start = 1'b0; rewind = 1'b0;
    for (int k = 1; k <= 40 && kind == 0; k++) begin
      @(negedge clock);
      if (var_rd_en) begin
        if (nreads == 0) first = int'(var_rd_idx);
        if (int'(var_rd_idx) != first + nreads) seq_ok = 0;
        nreads++;
      end
      if (dec_push && all_assigned) both = 1;
      if (dec_push) begin
        kind = 1; idx = int'(dec_idx); lat = k; busy_evt = int'(busy);
      end else if (all_assigned) begin
        kind = 2; lat = k; busy_evt = int'(busy);
      end
    end
  endtask

  task automatic exercise(input string tag, input logic [15:0] t, input int mode, input logic [5:0] ri,
                          input int ek, input int ei, input int el, input int en, input int ef);
    int kind, idx, lat, nrd, first, both, bevt, seq, mk, mi, ml, mn, mf;
    tab_bits = t;
    if (mode == 1) do_rewind(ri);
    if (mode != 0 && int'(ri) < mdl_sp) mdl_sp = int'(ri);
    model(mdl_sp, t, mk, mi, ml, mn, mf, mdl_sp);
    run_start(mode == 2, ri, kind, idx, lat, nrd, first, both, bevt, seq);
    check({tag, ".kind"}, kind, ek);
    check({tag, ".idx"}, idx, ei);
    check({tag, ".lat"}, lat, el);
    check({tag, ".nreads"}, nrd, en);
    check({tag, ".first_rd"}, first, ef);
    check({tag, ".push_and_all"}, both, 0);
    check({tag, ".busy_at_event"}, bevt, 0);
    check({tag, ".reads_in_order"}, seq, 1);
  endtask

  initial begin
    int k, i, l, n, f, nsp, mode, events, busy_seen;
    logic [15:0] t;
    logic [5:0] ri;

    vecs[0] = '{16'h0000, 0, 6'd0, 1, 0, 3, 2, 0};
    vecs[1] = '{16'h0000, 0, 6'd0, 1, 1, 3, 2, 1};
    vecs[2] = '{16'h4399, 2, 6'd0, 1, 5, 8, 7, 0};
    vecs[3] = '{16'h4545, 1, 6'd7, 1, 6, 3, 2, 6};
    vecs[4] = '{16'h4545, 1, 6'd2, 1, 2, 3, 2, 2};
    vecs[5] = '{16'h5555, 1, 6'd0, 2, -1, 10, 8, 0};
    vecs[6] = '{16'h5555, 0, 6'd0, 2, -1, 1, 0, -1};
    vecs[7] = '{16'h1555, 2, 6'd3, 1, 7, 7, 5, 3};
    vecs[8] = '{16'hFFFF, 2, 6'd5, 2, -1, 5, 3, 5};

    #12;
    check("reset.outs", int'({var_rd_en, dec_push, all_assigned, busy, var_rd_idx, dec_idx}), 0);
    @(negedge clock);
    reset = 1'b1;

    for (int v = 0; v < 9; v++) begin
      exercise($sformatf("vec%0d", v), vecs[v].tab, vecs[v].rw_mode, vecs[v].rw_idx,
               vecs[v].e_kind, vecs[v].e_idx, vecs[v].e_lat, vecs[v].e_nrd, vecs[v].e_first);
    end

    for (int r = 0; r < 30; r++) begin
      for (int j = 0; j < NV; j++) begin
        t[2*j +: 2] = ($urandom_range(0, 99) < 30) ? 2'b00 : 2'($urandom_range(1, 3));
      end
      mode = $urandom_range(0, 2);
      ri = 6'($urandom_range(0, 9));
      nsp = (mode != 0 && int'(ri) < mdl_sp) ? int'(ri) : mdl_sp;
      model(nsp, t, k, i, l, n, f, nsp);
      exercise($sformatf("rnd%0d", r), t, mode, ri, k, i, l, n, f);
    end

    // Bring pointer to 4, then abort a scan with rewind to 1; a mid-scan start must not restart it.
    exercise("h_setup", 16'h0015, 2, 6'd0, 1, 3, 6, 5, 0);
    tab_bits = 16'h5555;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("abort.first_rd", var_rd_en ? int'(var_rd_idx) : -1, 4);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("abort.busy_mid", int'(busy), 1);
    rewind = 1'b1; rewind_idx = 6'd1;
    @(posedge clock);
    #1 rewind = 1'b0;
    @(negedge clock);
    check("abort.busy_drop", int'(busy), 0);
    check("abort.rd_en_drop", int'(var_rd_en), 0);
    events = 0; busy_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (dec_push || all_assigned) events++;
      if (busy) busy_seen++;
    end
    check("abort.no_events", events, 0);
    check("abort.stays_idle", busy_seen, 0);
    mdl_sp = 1;
    exercise("h_after_abort", 16'h0000, 0, 6'd0, 1, 1, 3, 2, 1);

    // Reset in the middle of a scan clears every output at once.
    tab_bits = 16'h5555;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_mid.busy_before", int'(busy), 1);
    #1 reset = 1'b0;
    #1 check("rst_mid.outs", int'({var_rd_en, dec_push, all_assigned, busy, var_rd_idx, dec_idx}), 0);
    @(negedge clock);
    reset = 1'b1;
    mdl_sp = 0;
    exercise("h_after_reset", 16'h0000, 0, 6'd0, 1, 0, 3, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
